// File: rtl/prbs_gen.sv
// Parallel PRBS7/15/23/31 pattern generator with valid/ready output.
// Define PRBS_ERR_INJ_EN to build the bit-error injection logic and its counter.
module prbs_gen #(
    parameter int unsigned WIDTH = 80,
    parameter int unsigned CNT_W = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     start_i,
    input  logic                     stop_i,
    input  logic [1:0]               prbs_sel_i,
    input  logic [30:0]              seed_i,
    output logic [WIDTH-1:0]         data_o,
    output logic                     valid_o,
    input  logic                     ready_i,
    input  logic                     inj_req_i,
    input  logic [$clog2(WIDTH):0]   inj_num_i,
    output logic [CNT_W-1:0]         inj_cnt_o,
    output logic                     busy_o
);

    localparam int unsigned NW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

    state_e             state_q, state_d;
    logic               valid_q, valid_d;
    logic [1:0]         sel_q;
    logic [30:0]        lfsr_q;
    logic [WIDTH-1:0]   data_q;

    logic               xfer;
    logic               load;
    logic [30:0]        seed_val;
    logic [30:0]        src_state;
    logic [1:0]         src_sel;
    logic [WIDTH+30:0]  gen;
    logic [WIDTH-1:0]   word_mask;

    // Unrolled WIDTH-step Fibonacci advance; returns {next_state, word}, word[0] earliest.
    function automatic logic [WIDTH+30:0] prbs_word(input logic [30:0] s_in,
                                                    input logic [1:0]  sel);
        logic [30:0]      s;
        logic [WIDTH-1:0] w;
        logic             b;
        s = s_in;
        w = '0;
        for (int i = 0; i < WIDTH; i++) begin
            case (sel)
                2'b00:   b = s[6] ^ s[5];
                2'b01:   b = s[14] ^ s[13];
                2'b10:   b = s[22] ^ s[17];
                default: b = s[30] ^ s[27];
            endcase
            s    = {s[29:0], b};
            w[i] = b;
        end
        return {s, w};
    endfunction

    // All-zero seed would lock the LFSR; substitute all-ones of the selected length.
    always_comb begin
        logic [30:0] mask;
        case (prbs_sel_i)
            2'b00:   mask = 31'h0000_007F;
            2'b01:   mask = 31'h0000_7FFF;
            2'b10:   mask = 31'h007F_FFFF;
            default: mask = 31'h7FFF_FFFF;
        endcase
        seed_val = seed_i & mask;
        if (seed_val == '0) begin
            seed_val = mask;
        end
    end

    assign xfer      = valid_q & ready_i;
    assign src_state = (state_q == StIdle) ? seed_val : lfsr_q;
    assign src_sel   = (state_q == StIdle) ? prbs_sel_i : sel_q;
    assign gen       = prbs_word(src_state, src_sel);

    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        load    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d = StRun;
                    valid_d = 1'b1;
                    load    = 1'b1;
                end
            end
            StRun: begin
                if (stop_i) begin
                    if (xfer) begin
                        state_d = StIdle;
                        valid_d = 1'b0;
                    end else begin
                        state_d = StDrain;
                    end
                end else if (xfer) begin
                    load = 1'b1;
                end
            end
            StDrain: begin
                if (xfer) begin
                    state_d = StIdle;
                    valid_d = 1'b0;
                end
            end
            default: begin
                state_d = StIdle;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            valid_q <= 1'b0;
            sel_q   <= 2'b00;
            lfsr_q  <= '1;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            if (load) begin
                sel_q  <= src_sel;
                lfsr_q <= gen[WIDTH+30:WIDTH];
                data_q <= gen[WIDTH-1:0] ^ word_mask;
            end
        end
    end

`ifdef PRBS_ERR_INJ_EN
    logic              inj_armed_q;
    logic [NW-1:0]     inj_num_q;
    logic [CNT_W-1:0]  inj_cnt_q;
    logic [NW-1:0]     inj_num_clamped;
    logic [CNT_W:0]    cnt_sum;

    assign inj_num_clamped = (inj_num_i > NW'(WIDTH)) ? NW'(WIDTH) : inj_num_i;
    assign cnt_sum         = {1'b0, inj_cnt_q} + (CNT_W+1)'(inj_num_q);

    always_comb begin
        word_mask = '0;
        for (int i = 0; i < WIDTH; i++) begin
            word_mask[i] = inj_armed_q && (NW'(i) < inj_num_q);
        end
    end

    // A request coinciding with a load arms for the following load.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            inj_armed_q <= 1'b0;
            inj_num_q   <= '0;
            inj_cnt_q   <= '0;
        end else begin
            if (load && inj_armed_q) begin
                inj_armed_q <= 1'b0;
                inj_cnt_q   <= cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
            end
            if (inj_req_i) begin
                inj_armed_q <= 1'b1;
                inj_num_q   <= inj_num_clamped;
            end
        end
    end

    assign inj_cnt_o = inj_cnt_q;
`else
    logic unused_inj;
    assign unused_inj = ^{inj_req_i, inj_num_i};
    assign word_mask  = '0;
    assign inj_cnt_o  = '0;
`endif

    assign data_o  = data_q;
    assign valid_o = valid_q;
    assign busy_o  = (state_q != StIdle);

endmodule

// File: tb/tb_prbs_gen.sv
// Directed bench for prbs_gen: reset, PRBS7/15/23/31 sequences, stall, stop/drain,
// injection (expectations follow whether PRBS_ERR_INJ_EN is defined), async reset.
module tb_prbs_gen;
    localparam int unsigned WIDTH = 80;
    localparam int unsigned CNT_W = 32;
`ifdef PRBS_ERR_INJ_EN
    localparam bit InjEn = 1'b1;
`else
    localparam bit InjEn = 1'b0;
`endif

    logic                   clk;
    logic                   rst;
    logic                   start;
    logic                   stop;
    logic [1:0]             sel;
    logic [30:0]            seed;
    logic [WIDTH-1:0]       data;
    logic                   valid;
    logic                   ready;
    logic                   inj_req;
    logic [$clog2(WIDTH):0] inj_num;
    logic [CNT_W-1:0]       inj_cnt;
    logic                   busy;

    prbs_gen #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .start_i    (start),
        .stop_i     (stop),
        .prbs_sel_i (sel),
        .seed_i     (seed),
        .data_o     (data),
        .valid_o    (valid),
        .ready_i    (ready),
        .inj_req_i  (inj_req),
        .inj_num_i  (inj_num),
        .inj_cnt_o  (inj_cnt),
        .busy_o     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Serial reference LFSR straight from the polynomial definition.
    logic [30:0] ms;
    int          mn;
    int          mt;
    bit          stream[$];

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_word(output logic [WIDTH-1:0] w);
        logic b;
        for (int i = 0; i < WIDTH; i++) begin
            b    = ms[mn-1] ^ ms[mt-1];
            ms   = {ms[29:0], b};
            w[i] = b;
        end
    endtask

    task automatic push_word(input logic [WIDTH-1:0] w);
        for (int i = 0; i < WIDTH; i++) stream.push_back(w[i]);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        logic [WIDTH-1:0] g;
        logic [WIDTH-1:0] w1;
        logic [WIDTH-1:0] ones;
        logic [WIDTH-1:0] mask5;
        logic [6:0]       low7;
        int               bad;
        int               pop;

        ones  = '1;
        mask5 = WIDTH'(5'h1F);
        rst = 1'b1; start = 0; stop = 0; sel = 0; seed = 0; ready = 0; inj_req = 0; inj_num = 0;
        step(); step();
        chk("rst_data",  256'(data), 256'(0));
        chk("rst_valid", 256'(valid), 256'(0));
        chk("rst_busy",  256'(busy), 256'(0));
        chk("rst_cnt",   256'(inj_cnt), 256'(0));
        #2 rst = 1'b0;
        step();

        // PRBS7 from seed 7F: first seven bits 0000001 in time order.
        seed = 31'h7F; sel = 2'b00; start = 1'b1;
        ms = 31'h7F; mn = 7; mt = 6;
        step();
        start = 1'b0;
        chk("p7_valid", 256'(valid), 256'(1));
        chk("p7_busy",  256'(busy), 256'(1));
        low7 = data[6:0];
        chk("p7_first7", 256'(low7), 256'(7'h40));
        model_word(w1);
        chk("p7_word0", 256'(data), 256'(w1));
        stream.delete();
        push_word(w1);

        // Stall for five cycles: word must hold.
        for (int i = 0; i < 5; i++) begin
            step();
            chk("stall_hold", 256'(data), 256'(w1));
            chk("stall_valid", 256'(valid), 256'(1));
        end
        ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step();
            model_word(g);
            chk("p7_stream", 256'(data), 256'(g));
            push_word(g);
        end
        bad = 0;
        for (int i = 0; i + 127 < stream.size(); i++) if (stream[i] != stream[i+127]) bad++;
        chk("p7_period127", 256'(bad), 256'(0));
        pop = 0;
        for (int i = 0; i < 127; i++) pop += int'(stream[i]);
        chk("p7_pop127", 256'(pop), 256'(64));
        pop = 0;
        for (int i = 200; i < 327; i++) pop += int'(stream[i]);
        chk("p7_pop127_win2", 256'(pop), 256'(64));

        // Injection of 5 bits, then 100 (clamped to 80), then a clean word.
        ready = 1'b0; inj_req = 1'b1; inj_num = 5;
        step();
        inj_req = 1'b0; ready = 1'b1;
        chk("inj_arm_hold", 256'(data), 256'(g));
        step();
        model_word(g);
        chk("inj5_word", 256'(data), 256'(g ^ (InjEn ? mask5 : '0)));
        chk("inj5_cnt",  256'(inj_cnt), 256'(InjEn ? 5 : 0));
        ready = 1'b0; inj_req = 1'b1; inj_num = 100;
        step();
        inj_req = 1'b0; ready = 1'b1;
        step();
        model_word(g);
        chk("inj80_word", 256'(data), 256'(g ^ (InjEn ? ones : '0)));
        chk("inj80_cnt",  256'(inj_cnt), 256'(InjEn ? 85 : 0));
        step();
        ready = 1'b0;
        model_word(g);
        chk("inj_clean_word", 256'(data), 256'(g));
        chk("inj_clean_cnt",  256'(inj_cnt), 256'(InjEn ? 85 : 0));

        // STOP while stalled -> drain holds word until transfer.
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk("drain_valid", 256'(valid), 256'(1));
        chk("drain_busy",  256'(busy), 256'(1));
        chk("drain_data",  256'(data), 256'(g));
        step();
        chk("drain_hold", 256'(data), 256'(g));
        ready = 1'b1;
        step();
        ready = 1'b0;
        chk("drain_done_valid", 256'(valid), 256'(0));
        chk("drain_done_busy",  256'(busy), 256'(0));

        // Zero seed behaves as all-ones; START beats STOP in idle.
        seed = 31'h0; sel = 2'b00; start = 1'b1; stop = 1'b1;
        ms = 31'h7F; mn = 7; mt = 6;
        step();
        start = 1'b0; stop = 1'b0;
        model_word(g);
        chk("seed0_valid", 256'(valid), 256'(1));
        chk("seed0_word",  256'(data), 256'(g));
        low7 = data[6:0];
        chk("seed0_first7", 256'(low7), 256'(7'h40));

        // STOP with transfer goes straight to idle.
        ready = 1'b1; stop = 1'b1;
        step();
        ready = 1'b0; stop = 1'b0;
        chk("stopx_valid", 256'(valid), 256'(0));
        chk("stopx_busy",  256'(busy), 256'(0));

        // PRBS15 full-period popcount.
        seed = 31'h1; sel = 2'b01; start = 1'b1;
        ms = 31'h1; mn = 15; mt = 14;
        step();
        start = 1'b0; ready = 1'b1;
        stream.delete();
        for (int k = 0; k < 410; k++) begin
            model_word(g);
            chk("p15_word", 256'(data), 256'(g));
            push_word(g);
            step();
        end
        ready = 1'b0;
        pop = 0;
        for (int i = 0; i < 32767; i++) pop += int'(stream[i]);
        chk("p15_pop32767", 256'(pop), 256'(16384));

        // Async reset mid-run with injection armed.
        inj_req = 1'b1; inj_num = 3;
        step();
        inj_req = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", 256'(valid), 256'(0));
        chk("arst_busy",  256'(busy), 256'(0));
        chk("arst_cnt",   256'(inj_cnt), 256'(0));
        chk("arst_data",  256'(data), 256'(0));
        #1 rst = 1'b0;
        step();

        // PRBS23 after reset: no leftover injection.
        seed = 31'h12345; sel = 2'b10; start = 1'b1;
        ms = 31'h12345; mn = 23; mt = 18;
        step();
        start = 1'b0;
        model_word(g);
        chk("p23_word0", 256'(data), 256'(g));
        chk("p23_cnt0",  256'(inj_cnt), 256'(0));
        ready = 1'b1;
        step();
        model_word(g);
        chk("p23_word1", 256'(data), 256'(g));
        chk("p23_cnt1",  256'(inj_cnt), 256'(0));
        stop = 1'b1;
        step();
        ready = 1'b0; stop = 1'b0;

        // PRBS31.
        seed = 31'h7FFF_FFFF; sel = 2'b11; start = 1'b1;
        ms = 31'h7FFF_FFFF; mn = 31; mt = 28;
        step();
        start = 1'b0; ready = 1'b1;
        model_word(g);
        chk("p31_word0", 256'(data), 256'(g));
        step();
        ready = 1'b0;
        model_word(g);
        chk("p31_word1", 256'(data), 256'(g));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
